data_mem_ctrl: RTL and testbench

- Multi-region data-memory controller for the RISC-V core's load/store path.
- Accepts one request at a time over a valid/ready handshake.
- Decodes the address into NUM_REG byte-enabled RAM banks and applies RV32 load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW).
- Inserts configurable wait states, returns a single-cycle response, and reports misaligned, unmapped and illegal-funct3 accesses instead of silently floating the read bus.

---
 rtl/data_mem_ctrl_pkg.sv | 59 +++++
 rtl/data_mem_bank.sv | 36 +++
 rtl/data_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, fault causes,
// FSM state encoding and RV32 load/store sizing helpers.
package data_mem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_UNMAPPED = 2'd2;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'd3;

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_SB:   store_be = 4'b0001 << lo;
      F3_SH:   store_be = 4'b0011 << lo;
      F3_SW:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_SB:   store_data = {4{wd[7:0]}};
      F3_SH:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Shift the addressed byte/half down to bit 0, then extend per funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  load_extend = {24'h0, sh[7:0]};
      F3_LHU:  load_extend = {16'h0, sh[15:0]};
      F3_LW:   load_extend = sh;
      default: load_extend = sh;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// One byte-enabled RAM bank: synchronous write with byte enables, registered read.
module data_mem_bank #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Storage array carries no reset; contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-region RV32 data-memory controller with wait states and fault reporting.
// Optional fault counter enabled by defining FAULT_CNT_EN.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned             NUM_REG    = 2,
  parameter logic [32*NUM_REG-1:0]   REG_BASE   = {32'h1002_0000, 32'h1001_0000},
  parameter int unsigned             DEPTH_LOG2 = 10,
  parameter int unsigned             LATENCY    = 2
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  output logic        oRespValid,
  output logic [31:0] oReadData,
  output logic        oFault,
  output logic [1:0]  oFaultCause,
  output logic [15:0] oFaultCount
);

  localparam int unsigned IDX_W        = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [32:0] REGION_BYTES = 33'(4) << DEPTH_LOG2;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lo_q, lo_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            cause_q, cause_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_fault_q, resp_fault_d;
  logic [1:0]            resp_cause_q, resp_cause_d;

  logic                  hit_c, illegal_c, misalign_c, access_c;
  logic [IDX_W-1:0]      hit_idx_c;
  logic [DEPTH_LOG2-1:0] hit_widx_c;
  logic [31:0]           bank_rdata [NUM_REG];

  assign oReqReady = (state_q == ST_IDLE) & iRST_n;

  // Request decode; the downward scan lets the lowest overlapping region win.
  always_comb begin
    illegal_c  = iWrite ? (iFunct3 >= 3'd3) : (iFunct3 == 3'd3 || iFunct3 >= 3'd6);
    misalign_c = (iFunct3[1:0] == 2'b01 && iAddress[0]) ||
                 (iFunct3[1:0] == 2'b10 && iAddress[1:0] != 2'b00);
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    hit_widx_c = '0;
    for (int i = NUM_REG - 1; i >= 0; i--) begin
      if ({1'b0, iAddress} >= {1'b0, REG_BASE[32*i +: 32]} &&
          {1'b0, iAddress} <  {1'b0, REG_BASE[32*i +: 32]} + REGION_BYTES) begin
        hit_c      = 1'b1;
        hit_idx_c  = IDX_W'(i);
        hit_widx_c = DEPTH_LOG2'((iAddress - REG_BASE[32*i +: 32]) >> 2);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    lo_d         = lo_q;
    widx_d       = widx_q;
    idx_d        = idx_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cause_d      = cause_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    resp_cause_d = CAUSE_NONE;
    access_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iReqValid && oReqReady) begin
          write_d  = iWrite;
          funct3_d = iFunct3;
          lo_d     = iAddress[1:0];
          widx_d   = hit_widx_c;
          idx_d    = hit_idx_c;
          be_d     = store_be(iFunct3, iAddress[1:0]);
          wdata_d  = store_data(iFunct3, iWriteData);
          cnt_d    = CNT_W'(LATENCY - 1);
          if (illegal_c)       cause_d = CAUSE_FUNCT3;
          else if (misalign_c) cause_d = CAUSE_MISALIGN;
          else if (!hit_c)     cause_d = CAUSE_UNMAPPED;
          else                 cause_d = CAUSE_NONE;
          state_d = (cause_d != CAUSE_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        resp_fault_d = (cause_q != CAUSE_NONE);
        resp_cause_d = cause_q;
        if (cause_q == CAUSE_NONE && !write_q)
          resp_rdata_d = load_extend(funct3_q, lo_q, bank_rdata[idx_q]);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      funct3_q     <= '0;
      lo_q         <= '0;
      widx_q       <= '0;
      idx_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      cause_q      <= CAUSE_NONE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      resp_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      lo_q         <= lo_d;
      widx_q       <= widx_d;
      idx_q        <= idx_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cause_q      <= cause_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      resp_cause_q <= resp_cause_d;
    end
  end

  for (genvar g = 0; g < NUM_REG; g++) begin : g_bank
    logic we_c, re_c;
    assign we_c = access_c &  write_q & (idx_q == IDX_W'(g));
    assign re_c = access_c & ~write_q & (idx_q == IDX_W'(g));
    data_mem_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
      .clk_i   (iCLK),
      .rst_ni  (iRST_n),
      .we_i    (we_c),
      .re_i    (re_c),
      .addr_i  (widx_q),
      .be_i    (be_q),
      .wdata_i (wdata_q),
      .rdata_o (bank_rdata[g])
    );
  end

`ifdef FAULT_CNT_EN
  logic [15:0] fault_cnt_q;

  // Counts at the edge that launches a fault response; saturates.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) fault_cnt_q <= '0;
    else if (state_q == ST_RESP && cause_q != CAUSE_NONE && fault_cnt_q != 16'hFFFF)
      fault_cnt_q <= fault_cnt_q + 16'd1;
  end

  assign oFaultCount = fault_cnt_q;
`else
  assign oFaultCount = 16'h0000;
`endif

  assign oRespValid  = resp_valid_q;
  assign oReadData   = resp_rdata_q;
  assign oFault      = resp_fault_q;
  assign oFaultCause = resp_cause_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (default parameters, LATENCY = 2).
module tb_data_mem_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iWrite = 1'b0;
  logic [2:0]  iFunct3 = 3'd0;
  logic [31:0] iAddress = 32'h0;
  logic [31:0] iWriteData = 32'h0;
  logic        oRespValid;
  logic [31:0] oReadData;
  logic        oFault;
  logic [1:0]  oFaultCause;
  logic [15:0] oFaultCount;

  int n_cmp = 0;
  int n_err = 0;
  int exp_faults = 0;

  data_mem_ctrl dut (
    .iCLK        (iCLK),
    .iRST_n      (iRST_n),
    .iReqValid   (iReqValid),
    .oReqReady   (oReqReady),
    .iWrite      (iWrite),
    .iFunct3     (iFunct3),
    .iAddress    (iAddress),
    .iWriteData  (iWriteData),
    .oRespValid  (oRespValid),
    .oReadData   (oReadData),
    .oFault      (oFault),
    .oFaultCause (oFaultCause),
    .oFaultCount (oFaultCount)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef FAULT_CNT_EN
    return 16'(exp_faults);
`else
    return 16'h0000;
`endif
  endfunction

  // One request: handshake, bounded wait for the response, check it and the idle cycle after.
  task automatic xfer(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] exp_cause, input logic [31:0] exp_rd);
    int lat;
    int exp_lat;
    exp_lat = (exp_cause != 2'd0) ? 1 : 3;
    lat = 0;
    while (!oReqReady && lat < 20) begin
      @(posedge iCLK); #1; lat++;
    end
    iReqValid = 1'b1; iWrite = wr; iFunct3 = f3; iAddress = addr; iWriteData = wd;
    @(posedge iCLK); #1;
    iReqValid = 1'b0;
    check({tag, ".busy"}, 32'(oReqReady), 32'd0);
    lat = 0;
    while (!oRespValid && lat < 20) begin
      @(posedge iCLK); #1; lat++;
    end
    if (exp_cause != 2'd0) exp_faults++;
    check({tag, ".lat"},   32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, oReadData, exp_rd);
    check({tag, ".fault"}, 32'(oFault), 32'(exp_cause != 2'd0));
    check({tag, ".cause"}, 32'(oFaultCause), 32'(exp_cause));
    @(posedge iCLK); #1;
    check({tag, ".vld_off"},   32'(oRespValid), 32'd0);
    check({tag, ".rdata_off"}, oReadData, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst.ready", 32'(oReqReady), 32'd0);
    check("rst.valid", 32'(oRespValid), 32'd0);
    check("rst.rdata", oReadData, 32'h0);
    check("rst.fault", 32'(oFault), 32'd0);
    check("rst.cause", 32'(oFaultCause), 32'd0);
    check("rst.count", 32'(oFaultCount), 32'd0);
    @(negedge iCLK); iRST_n = 1'b1;
    @(posedge iCLK); #1;
    check("idle.ready", 32'(oReqReady), 32'd1);

    // Basic word store / load
    xfer("t1_sw", 1'b1, 3'd2, 32'h1001_0004, 32'hDEAD_BEEF, 2'd0, 32'h0);
    xfer("t1_lw", 1'b0, 3'd2, 32'h1001_0004, 32'h0,         2'd0, 32'hDEAD_BEEF);

    // Sub-word stores and sign/zero extension
    xfer("t2_sb",  1'b1, 3'd0, 32'h1001_0005, 32'h0000_0080, 2'd0, 32'h0);
    xfer("t2_lb",  1'b0, 3'd0, 32'h1001_0005, 32'h0, 2'd0, 32'hFFFF_FF80);
    xfer("t2_lbu", 1'b0, 3'd4, 32'h1001_0005, 32'h0, 2'd0, 32'h0000_0080);
    xfer("t2_lh",  1'b0, 3'd1, 32'h1001_0004, 32'h0, 2'd0, 32'hFFFF_80EF);
    xfer("t2_lw",  1'b0, 3'd2, 32'h1001_0004, 32'h0, 2'd0, 32'hDEAD_80EF);
    xfer("t2_lhu", 1'b0, 3'd5, 32'h1001_0006, 32'h0, 2'd0, 32'h0000_DEAD);
    xfer("t2_sh",  1'b1, 3'd1, 32'h1001_0006, 32'h0000_1234, 2'd0, 32'h0);
    xfer("t2_lw2", 1'b0, 3'd2, 32'h1001_0004, 32'h0, 2'd0, 32'h1234_80EF);

    // Misaligned access faults and leaves memory untouched
    xfer("t3_pre",  1'b1, 3'd2, 32'h1001_0000, 32'h0BAD_F00D, 2'd0, 32'h0);
    xfer("t3_lwma", 1'b0, 3'd2, 32'h1001_0002, 32'h0, 2'd1, 32'h0);
    xfer("t3_lw",   1'b0, 3'd2, 32'h1001_0000, 32'h0, 2'd0, 32'h0BAD_F00D);

    // Region bounds: last word mapped, one past unmapped, bank 1 independent
    xfer("t4_swtop", 1'b1, 3'd2, 32'h1001_0FFC, 32'h0FFC_0FFC, 2'd0, 32'h0);
    xfer("t4_lwtop", 1'b0, 3'd2, 32'h1001_0FFC, 32'h0, 2'd0, 32'h0FFC_0FFC);
    xfer("t4_swum",  1'b1, 3'd2, 32'h1001_1000, 32'hFFFF_FFFF, 2'd2, 32'h0);
    xfer("t4_lwalias", 1'b0, 3'd2, 32'h1001_0000, 32'h0, 2'd0, 32'h0BAD_F00D);
    xfer("t4_sw1",   1'b1, 3'd2, 32'h1002_0000, 32'h1234_5678, 2'd0, 32'h0);
    xfer("t4_lw1",   1'b0, 3'd2, 32'h1002_0000, 32'h0, 2'd0, 32'h1234_5678);
    xfer("t4_lw0",   1'b0, 3'd2, 32'h1001_0000, 32'h0, 2'd0, 32'h0BAD_F00D);

    // Illegal funct3
    xfer("t5_ld3", 1'b0, 3'd3, 32'h1001_0000, 32'h0, 2'd3, 32'h0);
    @(posedge iCLK); #1;
    check("t5.count", 32'(oFaultCount), 32'(exp_count()));

    // Priority: illegal over misaligned, misaligned over unmapped
    xfer("t5_st3",  1'b1, 3'd3, 32'h1001_0000, 32'h0, 2'd3, 32'h0);
    xfer("t5_ld6",  1'b0, 3'd6, 32'h1001_0003, 32'h0, 2'd3, 32'h0);
    xfer("t5_shmu", 1'b1, 3'd1, 32'h1001_1001, 32'h0, 2'd1, 32'h0);
    xfer("t5_lwlo", 1'b0, 3'd2, 32'h1000_FFFC, 32'h0, 2'd2, 32'h0);
    xfer("t5_lw0",  1'b0, 3'd2, 32'h1001_0000, 32'h0, 2'd0, 32'h0BAD_F00D);
    check("t5.count2", 32'(oFaultCount), 32'(exp_count()));

    // Reset during ACCESS aborts the store
    xfer("t6_pre", 1'b1, 3'd2, 32'h1001_0008, 32'h5555_1234, 2'd0, 32'h0);
    iReqValid = 1'b1; iWrite = 1'b1; iFunct3 = 3'd2;
    iAddress = 32'h1001_0008; iWriteData = 32'hAAAA_AAAA;
    @(posedge iCLK); #1;
    iReqValid = 1'b0;
    #2 iRST_n = 1'b0;
    #1;
    exp_faults = 0;
    check("t6.ready", 32'(oReqReady), 32'd0);
    check("t6.valid", 32'(oRespValid), 32'd0);
    check("t6.rdata", oReadData, 32'h0);
    check("t6.fault", 32'(oFault), 32'd0);
    check("t6.cause", 32'(oFaultCause), 32'd0);
    check("t6.count", 32'(oFaultCount), 32'd0);
    repeat (3) @(posedge iCLK);
    #1;
    check("t6.ready_hold", 32'(oReqReady), 32'd0);
    check("t6.valid_hold", 32'(oRespValid), 32'd0);
    @(negedge iCLK); iRST_n = 1'b1;
    @(posedge iCLK); #1;
    xfer("t6_lw", 1'b0, 3'd2, 32'h1001_0008, 32'h0, 2'd0, 32'h5555_1234);
    xfer("t6_lw1", 1'b0, 3'd2, 32'h1002_0000, 32'h0, 2'd0, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
